// File: rtl/apb_stream_router_pkg.sv
// Shared definitions for the APB stream router: register word offsets,
// CTRL bit positions, FRAME_LEN reset value and the default counter type.
package apb_stream_router_pkg;

   // Register offsets (byte addresses of 32-bit words)
   localparam int unsigned CTRL_OFF      = 32'h0000_0000;
   localparam int unsigned PORT_SEL_OFF  = 32'h0000_0004;
   localparam int unsigned PORT_MASK_OFF = 32'h0000_0008;
   localparam int unsigned FRAME_LEN_OFF = 32'h0000_000C;
   localparam int unsigned DROP_CNT_OFF  = 32'h0000_0010;
   localparam int unsigned PORT_CNT_BASE = 32'h0000_0020;

   // CTRL bit positions
   localparam int unsigned CTRL_EN_BIT   = 32'd0;
   localparam int unsigned CTRL_MODE_BIT = 32'd1;
   localparam int unsigned CTRL_CLR_BIT  = 32'd2;

   localparam logic [7:0] FRAME_LEN_RST = 8'd8;

   // Default width of the saturating status counters
   typedef logic [15:0] cnt_t;

endpackage

// File: rtl/apb_stream_router_if.sv
// Bus bundle for the APB stream router.
//   APB  : paddr, psel, penable, pwrite, pwdata -> prdata, pready, pslverr
//   beat : valid_in, data_in -> valid_out, out_port[NUM_PORTS]
// master = bench / upstream driver, slave = router.
interface apb_stream_router_if #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
);
   logic [ADDR_W-1:0]    paddr;
   logic                 psel;
   logic                 penable;
   logic                 pwrite;
   logic [DATA_W-1:0]    pwdata;
   logic [DATA_W-1:0]    prdata;
   logic                 pready;
   logic                 pslverr;
   logic                 valid_in;
   logic                 data_in;
   logic                 valid_out;
   logic [NUM_PORTS-1:0] out_port;

   modport master (
      output paddr, psel, penable, pwrite, pwdata, valid_in, data_in,
      input  prdata, pready, pslverr, valid_out, out_port
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, valid_in, data_in,
      output prdata, pready, pslverr, valid_out, out_port
   );
endinterface

// File: rtl/apb_router_next_port.sv
// Combinational search for the next set bit of a port mask strictly above
// 'cur', wrapping around; 'cur' itself is the last candidate. With
// cur = NUM_PORTS-1 the result is the lowest set bit.
//   mask : port enable mask      cur  : starting index
//   next : found index (cur if none)   none : mask has no set bit
module apb_router_next_port #(
   parameter int NUM_PORTS = 4,
   parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic [NUM_PORTS-1:0] mask,
   input  logic [IDX_W-1:0]     cur,
   output logic [IDX_W-1:0]     next,
   output logic                 none
);
   int   best_s;
   int   dist_s;
   logic take_s;

   assign none = (mask == '0);

   // Pick the set bit with the smallest forward distance from cur
   always_comb begin
      best_s = NUM_PORTS;
      dist_s = 0;
      take_s = 1'b0;
      next   = cur;
      for (int j = 0; j < NUM_PORTS; j++) begin
         dist_s = (j + NUM_PORTS - int'(cur) - 1) % NUM_PORTS;
         take_s = mask[j] && (dist_s < best_s);
         best_s = take_s ? dist_s : best_s;
         next   = take_s ? IDX_W'(j) : next;
      end
   end
endmodule

// File: rtl/apb_stream_router.sv
// APB-configured serial-bit router. Each accepted valid_in beat is
// forwarded one cycle later on out_port[target] with valid_out=1, either to
// a fixed PORT_SEL or round-robin over PORT_MASK in FRAME_LEN-beat frames.
//   pclk, preset : clock, synchronous active-high reset
//   bus (slave)  : APB register access + beat input/output
module apb_stream_router
   import apb_stream_router_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int CNT_W     = $bits(cnt_t)
) (
   input logic                 pclk,
   input logic                 preset,
   apb_stream_router_if.slave  bus
);
   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic                 en_r, mode_r;
   logic [3:0]           port_sel_r;
   logic [NUM_PORTS-1:0] mask_r;
   logic [7:0]           frame_len_r;
   logic [IDX_W-1:0]     ptr_r;
   logic [7:0]           beat_cnt_r;
   logic                 valid_out_r;
   logic [NUM_PORTS-1:0] out_port_r;
   logic [CNT_W-1:0]     drop_cnt_r;
   logic [CNT_W-1:0]     port_cnt_r [NUM_PORTS];

   logic acc_s, wr_s, restart_s, clr_s, mapped_s, ro_s, sel_ok_s;
   logic hit_ctrl_s, hit_sel_s, hit_mask_s, hit_len_s, hit_drop_s, hit_cnt_s;
   logic [NUM_PORTS-1:0] cnt_match_s;
   logic [IDX_W-1:0]     cnt_idx_s, sel_idx_s, target_s, from_ptr_s, from_jump_s, low_idx_s;
   logic [IDX_W-1:0]     adv_idx_s, rr_ptr_s, ptr_nxt_s;
   logic [7:0]           eff_len_s, cnt_base_s, rr_cnt_s, cnt_nxt_s;
   logic                 accept_s, mask_none_s, unused_none_s;
   logic [DATA_W-1:0]    rd_s;
   logic [NUM_PORTS-1:0] out_next_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // ---------------- APB decode ----------------
   assign acc_s      = bus.psel & bus.penable;
   assign wr_s       = acc_s & bus.pwrite;
   assign hit_ctrl_s = (bus.paddr == ADDR_W'(CTRL_OFF));
   assign hit_sel_s  = (bus.paddr == ADDR_W'(PORT_SEL_OFF));
   assign hit_mask_s = (bus.paddr == ADDR_W'(PORT_MASK_OFF));
   assign hit_len_s  = (bus.paddr == ADDR_W'(FRAME_LEN_OFF));
   assign hit_drop_s = (bus.paddr == ADDR_W'(DROP_CNT_OFF));
   assign hit_cnt_s  = |cnt_match_s;

   // Decode the PORT_CNT window into a one-hot match and its index
   always_comb begin
      cnt_idx_s = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cnt_match_s[i] = (bus.paddr == ADDR_W'(PORT_CNT_BASE + 32'd4 * i));
         cnt_idx_s      = cnt_idx_s | (IDX_W'(i) & {IDX_W{cnt_match_s[i]}});
      end
   end

   // Read mux and mapped/read-only classification of the current address
   always_comb begin
      rd_s     = '0;
      mapped_s = 1'b1;
      ro_s     = 1'b0;
      if (hit_ctrl_s) begin
         rd_s[CTRL_EN_BIT]   = en_r;
         rd_s[CTRL_MODE_BIT] = mode_r;
      end else if (hit_sel_s) begin
         rd_s = DATA_W'(port_sel_r);
      end else if (hit_mask_s) begin
         rd_s = DATA_W'(mask_r);
      end else if (hit_len_s) begin
         rd_s = DATA_W'(frame_len_r);
      end else if (hit_drop_s) begin
         rd_s = DATA_W'(drop_cnt_r);
         ro_s = 1'b1;
      end else if (hit_cnt_s) begin
         rd_s = DATA_W'(port_cnt_r[cnt_idx_s]);
         ro_s = 1'b1;
      end else begin
         mapped_s = 1'b0;
      end
   end

   assign bus.pready  = 1'b1;
   assign bus.pslverr = acc_s & (~mapped_s | (bus.pwrite & ro_s));
   assign bus.prdata  = (acc_s && !bus.pslverr) ? rd_s : '0;

   // Pointer restart on EN rising or any MODE change; counter clear strobe
   assign restart_s = wr_s & hit_ctrl_s &
                      ((bus.pwdata[CTRL_EN_BIT] & ~en_r) | (bus.pwdata[CTRL_MODE_BIT] ^ mode_r));
   assign clr_s     = wr_s & hit_ctrl_s & bus.pwdata[CTRL_CLR_BIT];

   // ---------------- routing ----------------
   apb_router_next_port #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_from_ptr (
      .mask(mask_r), .cur(ptr_r), .next(from_ptr_s), .none(mask_none_s));
   // Needed when a jump lands on a port and the 1-beat frame ends at once
   apb_router_next_port #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_from_jump (
      .mask(mask_r), .cur(from_ptr_s), .next(from_jump_s), .none(unused_none_s));
   apb_router_next_port #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_lowest (
      .mask(mask_r), .cur(IDX_W'(NUM_PORTS - 1)), .next(low_idx_s), .none());

   assign eff_len_s = (frame_len_r == 8'd0) ? 8'd1 : frame_len_r;
   assign sel_ok_s  = ({28'd0, port_sel_r} < 32'(NUM_PORTS));
   assign sel_idx_s = port_sel_r[IDX_W-1:0];

   // Beat acceptance, target selection and round-robin frame bookkeeping
   always_comb begin
      accept_s   = 1'b0;
      target_s   = ptr_r;
      cnt_base_s = beat_cnt_r;
      adv_idx_s  = from_ptr_s;
      rr_ptr_s   = ptr_r;
      rr_cnt_s   = beat_cnt_r;
      if (bus.valid_in && en_r && !mode_r) begin
         accept_s = sel_ok_s && mask_r[sel_idx_s];
         target_s = sel_idx_s;
      end else if (bus.valid_in && en_r && mode_r && !mask_none_s) begin
         accept_s = 1'b1;
         if (mask_r[ptr_r]) begin
            target_s   = ptr_r;
            cnt_base_s = beat_cnt_r;
            adv_idx_s  = from_ptr_s;
         end else begin
            // Pointer sits on a masked port: jump and start a fresh frame
            target_s   = from_ptr_s;
            cnt_base_s = 8'd0;
            adv_idx_s  = from_jump_s;
         end
         if ((cnt_base_s + 8'd1) >= eff_len_s) begin
            rr_ptr_s = adv_idx_s;
            rr_cnt_s = 8'd0;
         end else begin
            rr_ptr_s = target_s;
            rr_cnt_s = cnt_base_s + 8'd1;
         end
      end else begin
         accept_s = 1'b0;
      end
   end

   assign ptr_nxt_s  = restart_s ? (mask_none_s ? '0 : low_idx_s) : rr_ptr_s;
   assign cnt_nxt_s  = restart_s ? 8'd0 : rr_cnt_s;
   assign out_next_s = accept_s ? (NUM_PORTS'(bus.data_in) << target_s) : '0;

   // Configuration registers written over APB
   always_ff @(posedge pclk) begin
      if (preset) begin
         en_r        <= 1'b0;
         mode_r      <= 1'b0;
         port_sel_r  <= 4'd0;
         mask_r      <= '1;
         frame_len_r <= FRAME_LEN_RST;
      end else begin
         if (wr_s && hit_ctrl_s) begin
            en_r   <= bus.pwdata[CTRL_EN_BIT];
            mode_r <= bus.pwdata[CTRL_MODE_BIT];
         end
         if (wr_s && hit_sel_s)  port_sel_r  <= bus.pwdata[3:0];
         if (wr_s && hit_mask_s) mask_r      <= bus.pwdata[NUM_PORTS-1:0];
         if (wr_s && hit_len_s)  frame_len_r <= bus.pwdata[7:0];
      end
   end

   // Round-robin pointer and beat-in-frame count
   always_ff @(posedge pclk) begin
      if (preset) begin
         ptr_r      <= '0;
         beat_cnt_r <= 8'd0;
      end else begin
         ptr_r      <= ptr_nxt_s;
         beat_cnt_r <= cnt_nxt_s;
      end
   end

   // Registered beat output, one cycle after acceptance
   always_ff @(posedge pclk) begin
      if (preset) begin
         valid_out_r <= 1'b0;
         out_port_r  <= '0;
      end else begin
         valid_out_r <= accept_s;
         out_port_r  <= out_next_s;
      end
   end

   // Saturating drop/per-port counters; a clear overrides a same-cycle beat
   always_ff @(posedge pclk) begin
      if (preset || clr_s) begin
         drop_cnt_r <= '0;
         for (int i = 0; i < NUM_PORTS; i++) port_cnt_r[i] <= '0;
      end else begin
         if (bus.valid_in && !accept_s) drop_cnt_r <= sat_inc(drop_cnt_r);
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (accept_s && (target_s == IDX_W'(i))) port_cnt_r[i] <= sat_inc(port_cnt_r[i]);
         end
      end
   end

   assign bus.valid_out = valid_out_r;
   assign bus.out_port  = out_port_r;

endmodule

// File: tb/tb_apb_stream_router.sv
module tb_apb_stream_router;
   localparam int NP  = 4;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   apb_stream_router_if #(.NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32)) bus ();

   apb_stream_router #(.NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32), .CNT_W(CW)) dut (
      .pclk(clk), .preset(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit m_en, m_mode;
   int m_sel, m_mask, m_flen, m_drop, m_ptr, m_cnt;
   int m_pcnt [NP];

   logic [31:0]   last_rd;
   logic          last_err;
   logic [NP-1:0] last_out;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_en = 1'b0; m_mode = 1'b0; m_sel = 0; m_mask = (1 << NP) - 1; m_flen = 8;
      m_drop = 0; m_ptr = 0; m_cnt = 0;
      for (int i = 0; i < NP; i++) m_pcnt[i] = 0;
   endtask

   // Next enabled port strictly after 'from' going round the ring; -1 if none
   function automatic int next_set(input int from);
      for (int k = 1; k <= NP; k++) begin
         if (((m_mask >> ((from + k) % NP)) & 1) == 1) return (from + k) % NP;
      end
      return -1;
   endfunction

   task automatic m_read(input int a, output logic [31:0] d, output bit unm, output bit ro);
      d = 32'd0; unm = 1'b0; ro = 1'b0;
      case (a)
         0:  d = {30'd0, m_mode, m_en};
         4:  d = 32'(m_sel);
         8:  d = 32'(m_mask);
         12: d = 32'(m_flen);
         16: begin d = 32'(m_drop); ro = 1'b1; end
         default: begin
            if (a >= 32 && a < 32 + 4 * NP && (a % 4) == 0) begin
               d = 32'(m_pcnt[(a - 32) / 4]); ro = 1'b1;
            end else begin
               unm = 1'b1;
            end
         end
      endcase
   endtask

   // One clock cycle: drive, check APB combinational outputs, advance the
   // model, then check the registered beat output after the edge.
   task automatic cyc(input bit s, input bit e, input bit w, input int a,
                      input logic [31:0] wd, input bit v, input bit d);
      logic [31:0]   rd;
      bit            unm, ro, acc, taken, ne, nm;
      int            tgt, fl, l;
      logic [NP-1:0] ep;
      bus.psel = s; bus.penable = e; bus.pwrite = w; bus.paddr = 32'(a);
      bus.pwdata = wd; bus.valid_in = v; bus.data_in = d;
      acc = s & e;
      m_read(a, rd, unm, ro);
      #1;
      chk("pready", 32'(bus.pready), 32'd1);
      chk("pslverr", 32'(bus.pslverr), 32'(acc && (unm || (w && ro))));
      if (acc) last_err = bus.pslverr;
      if (acc && !w) begin
         chk("prdata", bus.prdata, unm ? 32'd0 : rd);
         last_rd = bus.prdata;
      end else if (!acc) begin
         chk("prdata_idle", bus.prdata, 32'd0);
      end
      taken = 1'b0; tgt = 0;
      if (!rst && v && m_en) begin
         if (!m_mode) begin
            if (m_sel < NP && ((m_mask >> m_sel) & 1) == 1) begin taken = 1'b1; tgt = m_sel; end
         end else if (m_mask != 0) begin
            if (((m_mask >> m_ptr) & 1) == 0) begin m_ptr = next_set(m_ptr); m_cnt = 0; end
            taken = 1'b1; tgt = m_ptr; m_cnt++;
            fl = (m_flen == 0) ? 1 : m_flen;
            if (m_cnt >= fl) begin m_ptr = next_set(m_ptr); m_cnt = 0; end
         end
      end
      if (!rst && v) begin
         if (taken) begin if (m_pcnt[tgt] < SAT) m_pcnt[tgt]++; end
         else if (m_drop < SAT) m_drop++;
      end
      ep = '0;
      if (taken) ep[tgt] = d;
      if (rst) begin
         m_reset();
      end else if (acc && w && !unm && !ro) begin
         case (a)
            0: begin
               ne = wd[0]; nm = wd[1];
               if ((ne && !m_en) || (nm != m_mode)) begin
                  l = next_set(NP - 1); m_ptr = (l < 0) ? 0 : l; m_cnt = 0;
               end
               if (wd[2]) begin
                  m_drop = 0;
                  for (int i = 0; i < NP; i++) m_pcnt[i] = 0;
               end
               m_en = ne; m_mode = nm;
            end
            4:  m_sel  = int'(wd & 32'hF);
            8:  m_mask = int'(wd & 32'((1 << NP) - 1));
            12: m_flen = int'(wd & 32'hFF);
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
      chk("valid_out", 32'(bus.valid_out), 32'(taken));
      chk("out_port", 32'(bus.out_port), 32'(ep));
      last_out = bus.out_port;
   endtask

   task automatic idle(input bit v, input bit d);
      cyc(1'b0, 1'b0, 1'b0, 0, 32'd0, v, d);
   endtask

   task automatic wr_beat(input int a, input logic [31:0] wd, input bit v, input bit d);
      cyc(1'b1, 1'b0, 1'b1, a, wd, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, a, wd, v, d);
   endtask

   task automatic wr(input int a, input logic [31:0] wd);
      wr_beat(a, wd, 1'b0, 1'b0);
   endtask

   task automatic rd(input int a);
      cyc(1'b1, 1'b0, 1'b0, a, 32'd0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, a, 32'd0, 1'b0, 1'b0);
   endtask

   int rr_exp [8] = '{0, 0, 1, 1, 3, 3, 0, 0};
   int addrs  [9] = '{0, 4, 8, 12, 16, 32, 36, 40, 44};
   int r, a;
   logic [31:0] wdv;

   initial begin
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'd0;
      bus.pwdata = 32'd0; bus.valid_in = 1'b0; bus.data_in = 1'b0;
      last_rd = 32'd0; last_err = 1'b0; last_out = '0;
      m_reset();

      // Reset, including a beat presented while reset is asserted
      rst = 1'b1;
      idle(1'b1, 1'b1);
      idle(1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 9; i++) rd(addrs[i]);
      rd(0);  chk("ctrl_rst", last_rd, 32'd0);
      rd(8);  chk("mask_rst", last_rd, 32'hF);
      rd(12); chk("flen_rst", last_rd, 32'd8);
      rd(20); chk("unmapped_err", 32'(last_err), 32'd1); chk("unmapped_rd", last_rd, 32'd0);

      // Fixed mode, port 2, bit stream 1,0,1
      wr(4, 32'd2); wr(0, 32'd1);
      idle(1'b1, 1'b1); chk("fix_b0", 32'(last_out), 32'h4);
      idle(1'b1, 1'b0); chk("fix_b1", 32'(last_out), 32'h0);
      idle(1'b1, 1'b1); chk("fix_b2", 32'(last_out), 32'h4);
      idle(1'b0, 1'b0);
      rd(40); chk("fix_cnt2", last_rd, 32'd3);

      // Round-robin, FRAME_LEN=2, mask 1011, counters cleared
      wr(12, 32'd2); wr(8, 32'hB); wr(0, 32'd7);
      for (int i = 0; i < 8; i++) begin
         idle(1'b1, 1'b1);
         chk("rr_port", 32'(last_out), 32'(1 << rr_exp[i]));
      end
      rd(32); chk("rr_cnt0", last_rd, 32'd4);
      rd(36); chk("rr_cnt1", last_rd, 32'd2);
      rd(40); chk("rr_cnt2", last_rd, 32'd0);
      rd(44); chk("rr_cnt3", last_rd, 32'd2);

      // Mid-frame mask change: pointer on masked port jumps, new frame
      idle(1'b1, 1'b1); chk("mid_p1", 32'(last_out), 32'h2);
      wr(8, 32'hD);
      idle(1'b1, 1'b1); chk("mid_jump", 32'(last_out), 32'h4);
      idle(1'b1, 1'b1); chk("mid_frame2", 32'(last_out), 32'h4);
      idle(1'b1, 1'b1); chk("mid_adv", 32'(last_out), 32'h8);

      // Drops: EN=0, then mask=0, then clear racing a beat
      wr(0, 32'd4);
      for (int i = 0; i < 5; i++) idle(1'b1, 1'($urandom_range(0, 1)));
      rd(16); chk("drop_en0", last_rd, 32'd5);
      wr(8, 32'd0); wr(0, 32'd1);
      for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);
      rd(16); chk("drop_mask0", last_rd, 32'd8);
      wr_beat(0, 32'd5, 1'b1, 1'b1);
      rd(16); chk("drop_clr", last_rd, 32'd0);

      // Saturation at 2^CNT_W-1 and RO write rejection
      wr(8, 32'hF); wr(4, 32'd0);
      for (int i = 0; i < 20; i++) idle(1'b1, 1'b1);
      rd(32); chk("sat_cnt0", last_rd, 32'd15);
      wr(32, 32'd5); chk("ro_wr_err", 32'(last_err), 32'd1);
      rd(32); chk("ro_unchanged", last_rd, 32'd15);

      // FRAME_LEN=0 acts as 1
      wr(12, 32'd0); wr(0, 32'd3);
      idle(1'b1, 1'b1); chk("len0_a", 32'(last_out), 32'h1);
      idle(1'b1, 1'b1); chk("len0_b", 32'(last_out), 32'h2);
      idle(1'b1, 1'b1); chk("len0_c", 32'(last_out), 32'h4);

      // Randomised traffic with interleaved register accesses
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 9));
         a = addrs[$urandom_range(0, 8)];
         if (r == 0) begin
            if (a == 0)       wdv = 32'($urandom_range(0, 7));
            else if (a == 12) wdv = 32'($urandom_range(0, 4));
            else              wdv = $urandom;
            wr_beat(a, wdv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else if (r == 1) begin
            rd((n % 7 == 0) ? 24 : a);
         end else begin
            idle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
      end
      for (int i = 0; i < 9; i++) rd(addrs[i]);

      // Reset with a pending beat
      idle(1'b1, 1'b1);
      rst = 1'b1;
      idle(1'b1, 1'b1);
      chk("rst_discard", 32'(last_out), 32'd0);
      rst = 1'b0;
      rd(8); chk("mask_after_rst", last_rd, 32'hF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/apb_stream_router.md
Name: apb_stream_router

Overview:
- APB-configured serial-bit router: each valid_in beat of data_in is forwarded to one of NUM_PORTS output ports.
- Successor to the fixed 4-port router.
  - Port count is parametrised.
  - Adds fixed and round-robin modes, a per-port enable mask and a frame length for round-robin.
  - Adds per-port beat counters, a drop counter and pslverr.
- Sits behind the APB agent interface in the RAL testbench; all control and status is in the register map below.

Parameters:
- NUM_PORTS, 4, number of output ports (2..16)
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- CNT_W, 16, width of the saturating counters (<= DATA_W)

Ports:
- pclk  in  1  clock
- preset  in  1  reset, synchronous, active-high
- paddr  in  ADDR_W  APB address
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB write
- pwdata  in  DATA_W  APB write data
- prdata  out  DATA_W  APB read data
- pready  out  1  APB ready, tied 1
- pslverr  out  1  APB error
- valid_in  in  1  input beat valid
- data_in  in  1  input bit
- valid_out  out  1  output beat valid
- out_port  out  NUM_PORTS  one bit per port

Behaviour:
- Reset (preset=1 at a pclk edge): all registers take their reset values; valid_out=0, out_port=0, counters=0, rr pointer=0, beat count=0.
- APB timing: zero wait states, pready=1.
  - Access phase is psel&penable.
  - A write commits at the end of the access cycle.
  - prdata is combinational during the access phase and 0 otherwise.
- pslverr=1 in the access phase for an unmapped address or a write to an RO register. Such a write is ignored; such a read returns 0.
- Register map (word offsets):
  - 0x00 CTRL RW: bit0 EN (reset 0), bit1 MODE (0 fixed, 1 round-robin). bit2 CNT_CLR is write-1, self-clearing and reads 0.
  - 0x04 PORT_SEL RW: [3:0], reset 0.
  - 0x08 PORT_MASK RW: [NUM_PORTS-1:0], reset all ones.
  - 0x0C FRAME_LEN RW: [7:0], reset 8; a value of 0 behaves as 1.
  - 0x10 DROP_CNT RO.
  - 0x20+4*i PORT_CNT[i] RO, for i < NUM_PORTS.
- Datapath (1-cycle registered latency):
  - On an accepted beat in cycle N: in N+1, valid_out=1, out_port[target]=data_in, and all other bits of out_port are 0.
  - In any cycle with no accepted beat, valid_out=0 and out_port=0.
- Fixed mode:
  - target = PORT_SEL.
  - The beat is dropped if EN=0, PORT_SEL>=NUM_PORTS, or PORT_MASK[PORT_SEL]=0.
- Round-robin mode:
  - target = rr pointer.
  - Each accepted beat increments the beat count. When the count reaches FRAME_LEN, the pointer advances to the next set mask bit above it (wrapping) and the count returns to 0.
  - If the pointer's mask bit is 0 when a beat arrives, the pointer first jumps to the next set bit (wrapping) and the count restarts at 0. The beat is routed there in the same cycle.
  - If PORT_MASK=0, every beat is dropped.
- Pointer restart:
  - An EN 0->1 transition or any change of MODE sets the pointer to the lowest set mask bit and the count to 0.
- Counters:
  - A dropped beat increments DROP_CNT; an accepted beat increments PORT_CNT[target].
  - All counters saturate at 2^CNT_W-1.
  - CNT_CLR zeroes all counters. When a clear and a beat fall in the same cycle, the clear wins and the counter ends at 0.
- Simultaneous APB write and beat: the beat uses the pre-write register values.
- Reset mid-frame discards any pending output beat (valid_out=0 on the next cycle).

Decomposition:
- apb_stream_router_pkg holds:
  - register offset localparams;
  - CTRL bit positions;
  - FRAME_LEN reset value;
  - a typedef for the counter width.
- Sub-module apb_router_next_port: combinational function, (mask, current index) -> next set index with wrap, plus a none-set flag. It is used for the jump, advance and restart cases.

Test Plan:
- Reset, then read all registers: CTRL=0, PORT_MASK=0xF, FRAME_LEN=8, counters=0, pslverr=0. A read of 0x14 gives pslverr=1 and prdata=0.
- Fixed mode: EN=1, PORT_SEL=2, drive the bit stream 1,0,1. Out_port=0b0100,0b0000,0b0100 with valid_out=1, each one cycle after the input. PORT_CNT[2]=3.
- Round-robin: FRAME_LEN=2, mask=0b1011, 8 beats of 1. The ports used are 0,0,1,1,3,3,0,0 and PORT_CNT = {4,2,0,2}.
- Mid-frame mask change: round-robin on port 1 after 1 beat; write mask=0b1101, then send a beat. It routes to port 2 and a new 2-beat frame starts.
- Drops: EN=0 with 5 beats gives DROP_CNT=5. With mask=0 and EN=1, 3 beats give DROP_CNT=8. Write CNT_CLR=1 in the same cycle as a beat: DROP_CNT=0.
- Saturation with CNT_W=4: 20 beats to port 0 give PORT_CNT[0]=15. A write to 0x20 gives pslverr=1 and the value is unchanged.
